simple_platform: RTL and testbench
==================================

SIMPLE_PLATFORM -- requirements
Module: simple_platform

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port wb_clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port request, input, 1 bit: host transaction request, sampled only when busy=0.
REQ-005 SHALL have port write, input, 1 bit: 1=write, 0=read.
REQ-006 SHALL have port address, input, 32 bits: byte address, word aligned.
REQ-007 SHALL have port byte_sel, input, 4 bits: byte lane enables for writes.
REQ-008 SHALL have port data_to_bus, input, 32 bits: write data.
REQ-009 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-010 SHALL have port ready_from_bus, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port error_from_bus, output, 1 bit: one-cycle error pulse, in the same cycle as ready_from_bus.
REQ-012 SHALL have port data_from_bus, output, 32 bits: read data, valid while ready_from_bus=1.
REQ-013 SHALL have port serial_out, output, 1 bit: transmitter line, idle high.

Function
REQ-014 SHALL contain one Wishbone classic master ("core"), one register slave ("slave_0") and one serial-transmitter slave ("slave_1"), connected by an internal wb_cyc/wb_stb/wb_we/wb_adr/wb_sel/wb_dat/wb_ack/wb_err bus with address decode.
REQ-015 Master states SHALL be IDLE, BUS and DONE.
REQ-016 IDLE: when request=1 at edge N, the master SHALL latch the inputs and enter BUS, and SHALL drive busy=1, wb_cyc=1 and wb_stb=1 from N+1.
REQ-017 BUS: the master SHALL hold cyc/stb until it samples ack or err, then drop cyc/stb and enter DONE.
REQ-018 DONE: the master SHALL pulse ready_from_bus for one cycle (plus error_from_bus on err), drive data_from_bus with the captured data, clear busy, and return to IDLE.
REQ-019 The round-trip latency from request to the ready_from_bus pulse SHALL be exactly 3 cycles.
REQ-020 The master SHALL ignore request while busy=1.
REQ-021 Each slave SHALL register its ack/err one cycle after seeing cyc&stb addressed to it; an address matching no slave SHALL be answered with err by the decoder after one cycle.
REQ-022 slave_0 SHALL provide four 32-bit R/W registers at 0x000–0x00C; writes SHALL update only the lanes enabled by byte_sel; reads SHALL return the full word.
REQ-023 slave_1 SHALL provide DATA at 0x100 (write-only, reads return 0) and STATUS at 0x104 (read-only; bit0=tx_busy, bit1=done).
REQ-024 Writing DATA with byte_sel[0]=1 while the transmitter is idle SHALL load byte [7:0] and start transmission; writing DATA while tx_busy=1 SHALL return err and leave the transmission unaffected.
REQ-025 Frame format SHALL be: start bit 0, eight data bits LSB first, stop bit 1, each bit lasting CLKS_PER_BIT cycles; serial_out SHALL change one cycle after the ack of the starting write.
REQ-026 Transmitter states SHALL be IDLE, START, DATA and STOP; done SHALL set at the end of STOP and be cleared by a STATUS read (the read returns done=1).
REQ-027 Writes to STATUS, or DATA writes with byte_sel[0]=0, SHALL be acked and ignored.

Reset
REQ-028 While wb_rst=1, outputs SHALL be immediately: busy=0, ready_from_bus=0, error_from_bus=0, data_from_bus=0, serial_out=1; all registers SHALL be 0 and all FSMs in IDLE.
REQ-029 Reset asserted mid-transaction or mid-frame SHALL abort it with no ready pulse, and the interrupted frame SHALL be lost.

Verification
REQ-030 Write 0xDEADBEEF, byte_sel=F to 0x004, then read 0x004 -> ready_from_bus 3 cycles after each request; read data 0xDEADBEEF, error_from_bus=0.
REQ-031 Write 0x000000AA, byte_sel=1 to 0x004 after REQ-030 -> read returns 0xDEADBEAA.
REQ-032 Read 0x200 -> ready_from_bus=1 and error_from_bus=1 in the same cycle; data_from_bus=0.
REQ-033 Write 0xA5 to 0x100 with CLKS_PER_BIT=4 -> serial_out shows 0,1,0,1,0,0,1,0,1,1, 4 cycles each; STATUS reads 0x1 during the frame, 0x2 after, then 0x0.
REQ-034 Write DATA during a frame -> error_from_bus=1 and the frame completes unchanged.
REQ-035 Assert wb_rst in the middle of a frame -> serial_out=1 and busy=0 immediately; STATUS then reads 0.

Source files
------------

// File: rtl/simple_platform.sv
// Host-driven Wishbone classic master with a register-file slave and a
// UART-style serial transmitter slave behind a one-hot address decoder.
module simple_platform #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        request,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byte_sel,
  input  logic [31:0] data_to_bus,
  output logic        busy,
  output logic        ready_from_bus,
  output logic        error_from_bus,
  output logic [31:0] data_from_bus,
  output logic        serial_out
);

  typedef enum logic [1:0] {M_IDLE, M_BUS, M_DONE} master_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  master_state_t m_state;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0]   wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]    wb_sel;

  logic          bus_req, hit_0, hit_1, acc_0, acc_1;
  logic          ack_0, ack_1, err_1, err_dec;
  logic [31:0]   dat_0, dat_1;
  logic [31:0]   regs [4];

  tx_state_t     tx_state;
  logic [7:0]    tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_done, tx_busy, tx_line, tx_last;

  assign bus_req  = wb_cyc & wb_stb;
  assign hit_0    = (wb_adr[31:4] == 28'h0) && (wb_adr[1:0] == 2'b00);
  assign hit_1    = (wb_adr[31:3] == 29'h20) && (wb_adr[1:0] == 2'b00);
  assign acc_0    = bus_req & hit_0 & ~ack_0;
  assign acc_1    = bus_req & hit_1 & ~ack_1 & ~err_1;
  assign wb_ack   = ack_0 | ack_1;
  assign wb_err   = err_1 | err_dec;
  assign wb_dat_r = dat_0 | dat_1;
  assign tx_busy  = (tx_state != TX_IDLE);
  assign tx_last  = (tx_cnt == CNT_LAST);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      m_state        <= M_IDLE;
      wb_cyc         <= 1'b0;
      wb_stb         <= 1'b0;
      wb_we          <= 1'b0;
      wb_adr         <= '0;
      wb_sel         <= '0;
      wb_dat_w       <= '0;
      busy           <= 1'b0;
      ready_from_bus <= 1'b0;
      error_from_bus <= 1'b0;
      data_from_bus  <= '0;
    end else begin
      case (m_state)
        M_IDLE: if (request) begin
          wb_cyc   <= 1'b1;
          wb_stb   <= 1'b1;
          wb_we    <= write;
          wb_adr   <= address;
          wb_sel   <= byte_sel;
          wb_dat_w <= data_to_bus;
          busy     <= 1'b1;
          m_state  <= M_BUS;
        end
        M_BUS: if (wb_ack || wb_err) begin
          wb_cyc         <= 1'b0;
          wb_stb         <= 1'b0;
          ready_from_bus <= 1'b1;
          error_from_bus <= wb_err;
          data_from_bus  <= (wb_we || wb_err) ? '0 : wb_dat_r;
          m_state        <= M_DONE;
        end
        M_DONE: begin
          ready_from_bus <= 1'b0;
          error_from_bus <= 1'b0;
          data_from_bus  <= '0;
          busy           <= 1'b0;
          m_state        <= M_IDLE;
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  // Unmapped addresses still get a one-cycle-late response so the master never stalls.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) err_dec <= 1'b0;
    else        err_dec <= bus_req & ~hit_0 & ~hit_1 & ~err_dec;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      ack_0 <= 1'b0;
      dat_0 <= '0;
    end else begin
      ack_0 <= acc_0;
      dat_0 <= '0;
      if (acc_0) begin
        if (wb_we) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) regs[wb_adr[3:2]][8*b +: 8] <= wb_dat_w[8*b +: 8];
        end else begin
          dat_0 <= regs[wb_adr[3:2]];
        end
      end
    end
  end

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      default:  tx_line = 1'b1;
    endcase
  end

  // Bus access is handled before the bit timer so a frame ending wins over a done-clearing read.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_done    <= 1'b0;
      serial_out <= 1'b1;
      ack_1      <= 1'b0;
      err_1      <= 1'b0;
      dat_1      <= '0;
    end else begin
      ack_1      <= 1'b0;
      err_1      <= 1'b0;
      dat_1      <= '0;
      serial_out <= tx_line;
      if (acc_1) begin
        if (wb_we && !wb_adr[2]) begin
          if (tx_busy) begin
            err_1 <= 1'b1;
          end else begin
            ack_1 <= 1'b1;
            if (wb_sel[0]) begin
              tx_shift <= wb_dat_w[7:0];
              tx_cnt   <= '0;
              tx_state <= TX_START;
            end
          end
        end else begin
          ack_1 <= 1'b1;
          if (!wb_we && wb_adr[2]) begin
            dat_1   <= {30'h0, tx_done, tx_busy};
            tx_done <= 1'b0;
          end
        end
      end
      case (tx_state)
        TX_START: if (tx_last) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + 8'd1;
        TX_DATA: if (tx_last) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) tx_state <= TX_STOP;
          else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end else tx_cnt <= tx_cnt + 8'd1;
        TX_STOP: if (tx_last) begin
          tx_cnt   <= '0;
          tx_done  <= 1'b1;
          tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_platform.sv
// Randomized bench for simple_platform: a transaction-level model predicts
// every response and the serial waveform, checked each cycle after the clock edge.
module tb_simple_platform;
  localparam int C = 4;

  logic        wb_clk = 1'b0, wb_rst = 1'b0, request = 1'b0, write = 1'b0;
  logic [31:0] address = '0, data_to_bus = '0;
  logic [3:0]  byte_sel = '0;
  logic        busy, ready_from_bus, error_from_bus, serial_out;
  logic [31:0] data_from_bus;

  int total = 0, bad = 0, cycle = 0;

  logic [31:0] m_regs [4];
  logic        m_done;
  bit          m_active, m_have_frame;
  int          m_frame_s;
  logic [7:0]  m_frame_byte;
  int          exp_rdy = -100, exp_bn = -100;
  logic        exp_err = 1'b0;
  logic [31:0] exp_data = '0;
  bit          exp_chk = 1'b0;
  bit          serial_log [int];

  simple_platform #(.CLKS_PER_BIT(C)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .request(request), .write(write),
    .address(address), .byte_sel(byte_sel), .data_to_bus(data_to_bus),
    .busy(busy), .ready_from_bus(ready_from_bus), .error_from_bus(error_from_bus),
    .data_from_bus(data_from_bus), .serial_out(serial_out)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_done = 1'b0;
    m_active = 0;
    m_have_frame = 0;
    exp_rdy = -100;
    exp_bn = -100;
  endtask

  // Expected line level after edge c: start 0, data LSB first, stop 1, C cycles each.
  function automatic logic exp_serial(int c);
    int t, k;
    t = c - (m_frame_s + 1);
    if (!m_have_frame || t < 0 || t >= 10 * C) return 1'b1;
    k = t / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_frame_byte[k - 1];
  endfunction

  // Slave access happens at edge n+1; the response is visible after edge n+2.
  task automatic model_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat, input int n);
    int a;
    a = n + 1;
    exp_bn = n;
    exp_rdy = n + 2;
    exp_err = 1'b0;
    exp_data = '0;
    if (m_active && a > m_frame_s + 10 * C) begin
      m_done = 1'b1;
      m_active = 0;
    end
    if (adr < 32'h10) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_regs[adr[3:2]][8*b +: 8] = dat[8*b +: 8];
      end else exp_data = m_regs[adr[3:2]];
    end else if (adr == 32'h100) begin
      if (we) begin
        if (m_active) exp_err = 1'b1;
        else if (sel[0]) begin
          m_active = 1;
          m_have_frame = 1;
          m_frame_s = a;
          m_frame_byte = dat[7:0];
        end
      end
    end else if (adr == 32'h104) begin
      if (!we) begin
        exp_data = {30'h0, m_done, m_active};
        m_done = 1'b0;
      end
    end else exp_err = 1'b1;
    exp_chk = !we || exp_err;
  endtask

  // Compare process: sample 1 time unit after every rising edge.
  initial begin
    forever begin
      @(posedge wb_clk);
      cycle++;
      #1;
      serial_log[cycle] = serial_out;
      checkOutput("serial_out", {31'h0, serial_out}, {31'h0, exp_serial(cycle)});
      checkOutput("ready", {31'h0, ready_from_bus}, {31'h0, cycle == exp_rdy});
      if (cycle == exp_rdy) begin
        checkOutput("error", {31'h0, error_from_bus}, {31'h0, exp_err});
        if (exp_chk) checkOutput("rdata", data_from_bus, exp_data);
      end else checkOutput("error", {31'h0, error_from_bus}, 32'h0);
      if (cycle == exp_bn || cycle == exp_bn + 1) checkOutput("busy", {31'h0, busy}, 32'h1);
      else if (cycle != exp_bn + 2) checkOutput("busy", {31'h0, busy}, 32'h0);
    end
  end

  // Issue one transaction from a negedge; optionally keep request high with junk while busy.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input bit spam,
                               output logic got_err, output logic [31:0] got_data, output int n);
    int lat;
    request = 1'b1; write = we; address = adr; byte_sel = sel; data_to_bus = dat;
    n = cycle + 1;
    model_access(we, adr, sel, dat, n);
    @(negedge wb_clk);
    if (spam) begin
      write = ~we; address = 32'h8; byte_sel = 4'hF; data_to_bus = $urandom;
    end else request = 1'b0;
    lat = 1;
    while (ready_from_bus !== 1'b1 && lat < 8) begin
      @(negedge wb_clk);
      lat++;
    end
    request = 1'b0;
    checkOutput("latency", lat, 3);
    got_err = error_from_bus;
    got_data = data_from_bus;
    @(negedge wb_clk);
  endtask

  task automatic resetMid();
    @(posedge wb_clk);
    #2;
    wb_rst = 1'b1;
    request = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_serial", {31'h0, serial_out}, 32'h1);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_ready", {31'h0, ready_from_bus}, 32'h0);
    checkOutput("rst_error", {31'h0, error_from_bus}, 32'h0);
    checkOutput("rst_data", data_from_bus, 32'h0);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge wb_clk);
  endtask

  initial begin
    logic        e;
    logic [31:0] d, adr;
    logic [9:0]  pat;
    int          n, fs;
    model_reset();
    #1 wb_rst = 1'b1;
    #1;
    checkOutput("init_serial", {31'h0, serial_out}, 32'h1);
    checkOutput("init_busy", {31'h0, busy}, 32'h0);
    checkOutput("init_ready", {31'h0, ready_from_bus}, 32'h0);
    checkOutput("init_data", data_from_bus, 32'h0);
    waitCycles(3);
    wb_rst = 1'b0;
    waitCycles(2);

    applyStimulus(1, 32'h4, 4'hF, 32'hDEADBEEF, 0, e, d, n);
    checkOutput("wr4_err", {31'h0, e}, 32'h0);
    applyStimulus(0, 32'h4, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("rd4_data", d, 32'hDEADBEEF);
    checkOutput("rd4_err", {31'h0, e}, 32'h0);
    applyStimulus(1, 32'h4, 4'h1, 32'h000000AA, 1, e, d, n);
    applyStimulus(0, 32'h4, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("rd4_lane", d, 32'hDEADBEAA);
    applyStimulus(0, 32'h200, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("unmapped_err", {31'h0, e}, 32'h1);
    checkOutput("unmapped_data", d, 32'h0);

    applyStimulus(1, 32'h100, 4'h1, 32'hA5, 0, e, d, n);
    fs = n + 2;
    applyStimulus(0, 32'h104, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("status_busy", d, 32'h1);
    applyStimulus(1, 32'h100, 4'h1, 32'h3C, 0, e, d, n);
    checkOutput("data_busy_err", {31'h0, e}, 32'h1);
    waitCycles(45);
    pat = 10'b1101001010;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < C; j++) begin
        if (serial_log.exists(fs + i * C + j))
          checkOutput("frame_a5", {31'h0, serial_log[fs + i * C + j]}, {31'h0, pat[i]});
        else checkOutput("frame_a5_missing", 32'h1, 32'h0);
      end
    applyStimulus(0, 32'h104, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("status_done", d, 32'h2);
    applyStimulus(0, 32'h104, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("status_clear", d, 32'h0);

    applyStimulus(1, 32'h104, 4'hF, 32'hFFFFFFFF, 0, e, d, n);
    checkOutput("status_wr_err", {31'h0, e}, 32'h0);
    applyStimulus(1, 32'h100, 4'hE, 32'h5A, 0, e, d, n);
    checkOutput("data_nolane_err", {31'h0, e}, 32'h0);
    applyStimulus(0, 32'h104, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("status_idle", d, 32'h0);

    applyStimulus(1, 32'h100, 4'h1, 32'h5A, 0, e, d, n);
    waitCycles(10);
    resetMid();
    applyStimulus(0, 32'h104, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("status_after_rst", d, 32'h0);

    applyStimulus(1, 32'h8, 4'hF, 32'h12345678, 0, e, d, n);
    request = 1'b1; write = 1'b1; address = 32'hC; byte_sel = 4'hF; data_to_bus = 32'h87654321;
    n = cycle + 1;
    model_access(1, 32'hC, 4'hF, 32'h87654321, n);
    @(negedge wb_clk);
    request = 1'b0;
    resetMid();
    applyStimulus(0, 32'h8, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("reg8_cleared", d, 32'h0);
    applyStimulus(0, 32'hC, 4'h0, 32'h0, 0, e, d, n);
    checkOutput("regC_aborted", d, 32'h0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: adr = 32'h0;
        1: adr = 32'h4;
        2: adr = 32'h8;
        3: adr = 32'hC;
        4, 5: adr = 32'h100;
        6: adr = 32'h104;
        7: adr = 32'h200;
        8: adr = 32'h108;
        default: adr = $urandom & 32'hFFFF_FFFC;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), adr, 4'($urandom), $urandom,
                    1'($urandom_range(0, 1)), e, d, n);
      waitCycles($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) waitCycles(45);
      if (i == 120) resetMid();
    end
    waitCycles(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
